matrix_scan_driver: RTL and testbench
=====================================

// Module: matrix_scan_driver
// PURPOSE
//  Parametrised scan driver for shift-register-driven LED matrices (Pmod Matrix256 and larger tiles).
//  Holds a double-buffered ROWSxCOLS frame of BPP-bit intensities and scans it row by row with PWM phases.
//  Serialises one-hot anode bits plus active-low cathode bits to the 74HC595-style chain on serial_clk/serial_data/rclk.
//  Game/app logic writes the back bank and requests a tear-free swap, which commits at the frame boundary.
// PARAMETERS
//  ROWS     16   matrix rows (anode bits per line), >=2
//  COLS     16   matrix columns (cathode bits per line), >=2
//  BPP      2    bits per pixel; PWM phases per frame P = 2**BPP
//  CLK_DIV  100  clk cycles per serial_clk half-period, >=1
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  synchronous reset, active high
//  wr_en        in   1                  write pixel into back bank this cycle
//  wr_row       in   $clog2(ROWS)       pixel row
//  wr_col       in   $clog2(COLS)       pixel column
//  wr_data      in   BPP                pixel intensity (0 = off)
//  swap_req     in   1                  request front/back bank swap (pulse)
//  swap_pending out  1                  swap requested, not yet committed
//  blank        in   1                  force all cathodes off (1) for lines started while high
//  frame_done   out  1                  1-clk pulse when the last line of the last phase is latched
//  serial_clk   out  1                  shift clock to chain
//  serial_data  out  1                  shift data to chain
//  rclk         out  1                  storage-register latch clock
//  clear        out  1                  active-low chain clear (SRCLR)
// BEHAVIOUR
//  Reset: serial_clk=0, serial_data=0, rclk=0, clear=0, frame_done=0, swap_pending=0; both banks all 0,
//   front=bank0, row=0, phase=0, FSM=SHIFT at bit 0. clear=1 from first cycle after rst deasserts.
//  Bit slot = 2*CLK_DIV clk cycles: serial_clk low for first CLK_DIV, high for second CLK_DIV.
//   serial_data changes only at slot start (serial_clk falling/low edge); stable across rising edge.
//  Line = ROWS+COLS data slots (FSM SHIFT) then 1 latch slot (FSM LATCH): total ROWS+COLS+1 slots.
//   Slot i<ROWS: serial_data = (i==row). Slot ROWS+j: serial_data = 0 (lit) iff front[row][j] > phase
//   and blank sampled low at line start; else 1.
//  LATCH slot: serial_clk held 0, serial_data=0, rclk=1 whole slot; rclk=0 in all other slots.
//  Counter order: row increments each line; on row wrap (ROWS-1 -> 0) phase increments; on phase
//   wrap (P-1 -> 0) frame ends. Pixel value v is lit in v of P phases; max duty (P-1)/P.
//  frame_done: 1-clk pulse on final clk of LATCH slot for row=ROWS-1, phase=P-1.
//  Swap: swap_req sets swap_pending (no effect if already set). Commit on the frame_done cycle:
//   front toggles, swap_pending clears. swap_req on the commit cycle re-arms pending for next frame.
//   No copy: after swap the back bank holds the previous front frame.
//  Writes: wr_en writes back bank next edge; write on commit cycle lands in the pre-swap back bank
//   (becomes visible). wr_row>=ROWS or wr_col>=COLS: write ignored. Front bank never written.
//  Reset mid-line: line aborted, outputs return to reset values same edge; no partial rclk pulse.
//  Widths: slot counter $clog2(ROWS+COLS+1), divider $clog2(CLK_DIV), phase BPP bits, compare unsigned.
// TESTING
//  ROWS=COLS=4,BPP=2,CLK_DIV=2: reset, idle -> clear=0 in reset then 1; 9-slot lines, each 4 clk;
//   anode bits 1000,0100,0010,0001 per row; cathodes all 1; rclk high 4 clk per line.
//  Write (1,2)=3, swap_req, run -> swap_pending=1 until frame_done; then row1 line cathode bit2=0 in
//   phases 0,1,2, =1 in phase 3; frame_done every 4*4*9*4=576 clk.
//  Write (0,0)=1 without swap -> output unchanged for 2 frames; swap -> bit lit only in phase 0.
//  swap_req coincident with frame_done and a write to (3,3)=2 -> current swap commits with (3,3)=2
//   visible; pending=1 again; next frame_done swaps back to old bank.
//  blank=1 from mid-line -> current line unchanged, all later lines cathodes 1, anodes still scan.
//  Assert rst during slot 5 -> outputs zero next edge, no rclk pulse; restart at row0 phase0, banks 0.

Source files
------------

// File: rtl/matrix_scan_driver_if.sv
// Host-side port bundle of the LED matrix scan driver: pixel writes, bank swap and blanking.
// The application side uses the master modport, the scan driver uses the slave modport.
interface matrix_scan_driver_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int BPP  = 2
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [BPP-1:0] wr_data;
  logic          swap_req;
  logic          swap_pending;
  logic          blank;
  logic          frame_done;

  modport master (
    output wr_en, wr_row, wr_col, wr_data, swap_req, blank,
    input  swap_pending, frame_done
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, swap_req, blank,
    output swap_pending, frame_done
  );
endinterface

// File: rtl/matrix_scan_driver.sv
// Row-scanning PWM driver for 74HC595-chained LED matrices with a double-buffered frame store.
// Each line shifts ROWS one-hot anode bits then COLS active-low cathode bits, followed by a latch slot.
module matrix_scan_driver #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int BPP     = 2,
  parameter int CLK_DIV = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_scan_driver_if.slave     host,
  output logic                    serial_clk,
  output logic                    serial_data,
  output logic                    rclk,
  output logic                    clear
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(ROWS + COLS + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [SW-1:0] ROW_SLOTS      = SW'(ROWS);
  localparam logic [SW-1:0] LAST_DATA_SLOT = SW'(ROWS + COLS - 1);
  localparam logic [DW-1:0] DIV_LAST       = DW'(CLK_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST       = RW'(ROWS - 1);
  localparam logic [RW:0]   ROWS_W         = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COLS_W         = (CW + 1)'(COLS);

  typedef enum logic [0:0] {
    ST_SHIFT = 1'b0,
    ST_LATCH = 1'b1
  } state_e;

  // Counters hold the position of the next output cycle; outputs are registered from it.
  state_e         state_q, state_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [DW-1:0]  div_q, div_d;
  logic           half_q, half_d;
  logic [RW-1:0]  row_q, row_d;
  logic [BPP-1:0] phase_q, phase_d;
  logic           front_q, front_d;
  logic           pending_q, pending_d;
  logic           blank_line_q, blank_line_d;
  logic [BPP-1:0] bank_q [2][ROWS][COLS];
  logic [BPP-1:0] bank_d [2][ROWS][COLS];
  logic           sclk_q, sclk_d;
  logic           sdata_q, sdata_d;
  logic           rclk_q, rclk_d;
  logic           clear_q, clear_d;
  logic           frame_done_q, frame_done_d;

  logic           slot_end_s;
  logic           line_start_s;
  logic           frame_end_s;
  logic           commit_s;
  logic [CW-1:0]  col_s;
  logic [BPP-1:0] pixel_s;

  // Next-state logic: scan position, bank swap, pixel writes and registered pin values.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    div_d        = div_q;
    half_d       = half_q;
    row_d        = row_q;
    phase_d      = phase_q;
    front_d      = front_q;
    pending_d    = pending_q;
    blank_line_d = blank_line_q;
    bank_d       = bank_q;
    sclk_d       = 1'b0;
    sdata_d      = 1'b0;
    rclk_d       = 1'b0;
    clear_d      = 1'b1;
    col_s        = CW'(slot_q - ROW_SLOTS);
    pixel_s      = {BPP{1'b0}};

    slot_end_s   = half_q && (div_q == DIV_LAST);
    line_start_s = (state_q == ST_SHIFT) && (slot_q == {SW{1'b0}}) &&
                   !half_q && (div_q == {DW{1'b0}});
    frame_end_s  = slot_end_s && (state_q == ST_LATCH) && (row_q == ROW_LAST) &&
                   (phase_q == {BPP{1'b1}});
    commit_s     = frame_done_q && pending_q;

    if (div_q == DIV_LAST) begin
      div_d  = {DW{1'b0}};
      half_d = ~half_q;
    end else begin
      div_d  = div_q + DW'(1);
      half_d = half_q;
    end

    if (slot_end_s) begin
      case (state_q)
        ST_SHIFT: begin
          slot_d = slot_q + SW'(1);
          if (slot_q == LAST_DATA_SLOT) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_LATCH: begin
          state_d = ST_SHIFT;
          slot_d  = {SW{1'b0}};
          if (row_q == ROW_LAST) begin
            row_d   = {RW{1'b0}};
            phase_d = phase_q + BPP'(1);
          end else begin
            row_d   = row_q + RW'(1);
            phase_d = phase_q;
          end
        end
        default: begin
          state_d = ST_SHIFT;
          slot_d  = {SW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Blank is only honoured for whole lines, so it is captured once at the line start.
    if (line_start_s) begin
      blank_line_d = host.blank;
    end else begin
      blank_line_d = blank_line_q;
    end

    case (state_q)
      ST_SHIFT: begin
        sclk_d = half_q;
        rclk_d = 1'b0;
        if (slot_q < ROW_SLOTS) begin
          sdata_d = (RW'(slot_q) == row_q);
        end else begin
          pixel_s = bank_q[front_q][row_q][col_s];
          sdata_d = ~(~blank_line_q && (pixel_s > phase_q));
        end
      end
      ST_LATCH: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        rclk_d  = 1'b1;
      end
      default: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        rclk_d  = 1'b0;
      end
    endcase

    frame_done_d = frame_end_s;

    // A request arriving on the commit cycle re-arms for the following frame.
    if (commit_s) begin
      front_d   = ~front_q;
      pending_d = host.swap_req;
    end else if (host.swap_req) begin
      front_d   = front_q;
      pending_d = 1'b1;
    end else begin
      front_d   = front_q;
      pending_d = pending_q;
    end

    if (host.wr_en && ({1'b0, host.wr_row} < ROWS_W) && ({1'b0, host.wr_col} < COLS_W)) begin
      bank_d[~front_q][host.wr_row][host.wr_col] = host.wr_data;
    end else begin
      bank_d = bank_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SHIFT;
      slot_q       <= {SW{1'b0}};
      div_q        <= {DW{1'b0}};
      half_q       <= 1'b0;
      row_q        <= {RW{1'b0}};
      phase_q      <= {BPP{1'b0}};
      front_q      <= 1'b0;
      pending_q    <= 1'b0;
      blank_line_q <= 1'b0;
      bank_q       <= '{default: '0};
      sclk_q       <= 1'b0;
      sdata_q      <= 1'b0;
      rclk_q       <= 1'b0;
      clear_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      div_q        <= div_d;
      half_q       <= half_d;
      row_q        <= row_d;
      phase_q      <= phase_d;
      front_q      <= front_d;
      pending_q    <= pending_d;
      blank_line_q <= blank_line_d;
      bank_q       <= bank_d;
      sclk_q       <= sclk_d;
      sdata_q      <= sdata_d;
      rclk_q       <= rclk_d;
      clear_q      <= clear_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign serial_clk        = sclk_q;
  assign serial_data       = sdata_q;
  assign rclk              = rclk_q;
  assign clear             = clear_q;
  assign host.swap_pending = pending_q;
  assign host.frame_done   = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver on a 4x4, 2-bpp tile with CLK_DIV=2.
// Stimulus pushes expected shifted lines per frame; a monitor rebuilds lines from the pins and compares.
module tb_matrix_scan_driver;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int BPP        = 2;
  localparam int CLK_DIV    = 2;
  localparam int P          = 4;
  localparam int FRAME_CLKS = 576;
  localparam int SLOT_CLKS  = 4;

  logic clk = 1'b0;
  logic rst;
  logic serial_clk, serial_data, rclk, clear;

  matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP)) bus ();

  matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP), .CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (bus),
    .serial_clk  (serial_clk),
    .serial_data (serial_data),
    .rclk        (rclk),
    .clear       (clear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_fd = -1;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]     exp_q [$];
  logic [BPP-1:0] mb [2][ROWS][COLS];
  logic           mfront;
  logic           mpending;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mb[b][r][c] = '0;
    mfront   = 1'b0;
    mpending = 1'b0;
  endtask

  // Lines with index >= blank_from are expected fully dark.
  task automatic push_frame(input int blank_from);
    logic [3:0] an, ca;
    for (int ph = 0; ph < P; ph++) begin
      for (int r = 0; r < ROWS; r++) begin
        an = 4'b1000 >> r;
        for (int j = 0; j < COLS; j++) begin
          if (ph * ROWS + r >= blank_from) ca[3-j] = 1'b1;
          else ca[3-j] = (int'(mb[mfront][r][j]) > ph) ? 1'b0 : 1'b1;
        end
        exp_q.push_back({an, ca});
      end
    end
  endtask

  task automatic write_px(input int r, input int c, input int d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_row = r[1:0]; bus.wr_col = c[1:0]; bus.wr_data = d[1:0];
    mb[~mfront][r][c] = d[1:0];
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic swap_pulse();
    @(negedge clk);
    bus.swap_req = 1'b1;
    mpending = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    check("swap_pending_set", int'(bus.swap_pending), 1);
  endtask

  // Waits for frame_done, optionally driving swap/write/blank-release on the done cycle.
  task automatic wait_fd(input bit co_swap, input bit co_wr, input int r, input int c,
                         input int d, input bit blank_off);
    bit seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("frame_done_timeout", 0, 1);
      return;
    end
    if (last_fd >= 0) check("frame_period", cyc - last_fd, FRAME_CLKS);
    last_fd = cyc;
    check("pending_at_done", int'(bus.swap_pending), int'(mpending));
    if (blank_off) bus.blank = 1'b0;
    if (co_swap) bus.swap_req = 1'b1;
    if (co_wr) begin
      bus.wr_en = 1'b1; bus.wr_row = r[1:0]; bus.wr_col = c[1:0]; bus.wr_data = d[1:0];
      mb[~mfront][r][c] = d[1:0];
    end
    if (mpending) begin
      mfront   = ~mfront;
      mpending = co_swap;
    end else if (co_swap) begin
      mpending = 1'b1;
    end
    @(negedge clk);
    bus.swap_req = 1'b0;
    bus.wr_en    = 1'b0;
    check("pending_after_done", int'(bus.swap_pending), int'(mpending));
    check("frame_done_pulse", int'(bus.frame_done), 0);
  endtask

  // Monitor: rebuild each shifted line at serial_clk rises, compare on the latch pulse.
  logic [7:0] cap;
  int         bcnt, rw;
  bit         viol;
  logic       ps, pd, pr;
  logic [7:0] exp_line;

  always @(negedge clk) begin
    if (rst) begin
      cap = '0; bcnt = 0; viol = 1'b0; rw = 0;
      ps = 1'b0; pd = 1'b0; pr = 1'b0;
    end else begin
      if (serial_clk && !ps) begin
        cap = {cap[6:0], serial_data};
        bcnt++;
      end
      if (serial_clk && ps && (serial_data != pd)) viol = 1'b1;
      if (rclk && !pr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL line_unexpected: got bits %b, none expected (t=%0t)", cap, $time);
        end else begin
          exp_line = exp_q.pop_front();
          if (cap !== exp_line || bcnt != 8 || viol) begin
            errors++;
            $display("FAIL line_bits: got %b (%0d clocks, unstable=%0d), expected %b (8 clocks) (t=%0t)",
                     cap, bcnt, viol, exp_line, $time);
          end
        end
        cap = '0; bcnt = 0; viol = 1'b0; rw = 1;
      end else if (rclk && pr) begin
        rw++;
      end
      if (!rclk && pr) check("rclk_width", rw, SLOT_CLKS);
      ps = serial_clk; pd = serial_data; pr = rclk;
    end
  end

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.swap_req = 1'b0; bus.blank = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_serial_clk", int'(serial_clk), 0);
    check("rst_serial_data", int'(serial_data), 0);
    check("rst_rclk", int'(rclk), 0);
    check("rst_clear", int'(clear), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_swap_pending", int'(bus.swap_pending), 0);
    rst = 1'b0;
    push_frame(ROWS * P);
    @(negedge clk);
    check("clear_after_rst", int'(clear), 1);

    wait_fd(0, 0, 0, 0, 0, 0);
    push_frame(ROWS * P);
    write_px(1, 2, 3);
    swap_pulse();
    wait_fd(0, 0, 0, 0, 0, 0);
    push_frame(ROWS * P);

    write_px(0, 0, 1);
    wait_fd(0, 0, 0, 0, 0, 0);
    push_frame(ROWS * P);
    wait_fd(0, 0, 0, 0, 0, 0);
    push_frame(ROWS * P);
    swap_pulse();
    wait_fd(0, 0, 0, 0, 0, 0);
    push_frame(ROWS * P);

    swap_pulse();
    wait_fd(1, 1, 3, 3, 2, 0);
    push_frame(ROWS * P);
    wait_fd(0, 0, 0, 0, 0, 0);

    push_frame(1);
    repeat (18) @(negedge clk);
    bus.blank = 1'b1;
    wait_fd(0, 0, 0, 0, 0, 1);
    push_frame(ROWS * P);
    wait_fd(0, 0, 0, 0, 0, 0);

    push_frame(ROWS * P);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_serial_clk", int'(serial_clk), 0);
    check("midrst_serial_data", int'(serial_data), 0);
    check("midrst_rclk", int'(rclk), 0);
    check("midrst_clear", int'(clear), 0);
    check("midrst_swap_pending", int'(bus.swap_pending), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_fd = -1;
    push_frame(ROWS * P);
    swap_pulse();
    wait_fd(0, 0, 0, 0, 0, 0);
    push_frame(ROWS * P);
    wait_fd(0, 0, 0, 0, 0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
